// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FSM sequencer for a fetch/decode/execute
// datapath supporting ADD, ADDI and BEQ.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            leaves IDLE (sampled only in IDLE)
//   stop             sampled at retirement (WB/BR); returns to IDLE
//   opcode/funct3/funct7  instruction fields from the IR
//   zero             ALU zero flag; selects the branch target in BR
//   imem_ready       instruction memory data valid this cycle
//   imem_req         fetch request, high for the whole of FETCH
//   ir_write         latch the IR (FETCH && imem_ready)
//   pc_write, pcsrc  PC update enable; 0: PC+4, 1: branch target
//   alusrc, aluctl   ALU B-operand select and operation (0010 add, 0110 sub)
//   regwrite         register file write enable (WB only)
//   busy, halted     activity / halt status
//   err              sticky error, set on entering HALT
//   instr_count      retired instruction count (wraps silently)
module multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pcsrc,
  output logic             alusrc,
  output logic [3:0]       aluctl,
  output logic             regwrite,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BR, S_HALT
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  // Timeout fires on the FETCH_TIMEOUT-th consecutive stalled cycle.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       is_addi;   // captured in DECODE, steers alusrc in EXEC/WB
  logic       err_q;

  logic dec_add, dec_addi, dec_beq;
  assign dec_add  = (opcode == OP_RTYPE) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign dec_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
  assign dec_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      is_addi     <= 1'b0;
      err_q       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            err_q    <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          is_addi <= dec_addi;
          if (dec_add || dec_addi) state <= S_EXEC;
          else if (dec_beq)        state <= S_BR;
          else begin
            err_q <= 1'b1;
            state <= S_HALT;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB, S_BR: begin
          instr_count <= instr_count + CNT_W'(1);
          state       <= stop ? S_IDLE : S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls are a pure decode of the registered state; only
  // ir_write (imem_ready) and pcsrc (zero) look at live inputs.
  always_comb begin
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pcsrc    = 1'b0;
    alusrc   = 1'b0;
    aluctl   = ALU_ADD;
    regwrite = 1'b0;
    busy     = (state != S_IDLE) && (state != S_HALT);
    halted   = (state == S_HALT);
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: alusrc = is_addi;
      S_WB: begin
        alusrc   = is_addi;
        regwrite = 1'b1;
        pc_write = 1'b1;
      end
      S_BR: begin
        aluctl   = ALU_SUB;
        pc_write = 1'b1;
        pcsrc    = zero;
      end
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step drives inputs, queues the
// expected output vector, then pops and compares it mid-cycle.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, start, stop, zero, imem_ready;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic             imem_req, ir_write, pc_write, pcsrc, alusrc, regwrite;
  logic             busy, halted, err;
  logic [3:0]       aluctl;
  logic [CNT_W-1:0] instr_count;

  multicycle_ctrl #(.FETCH_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .imem_ready(imem_ready), .imem_req(imem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pcsrc(pcsrc), .alusrc(alusrc), .aluctl(aluctl),
    .regwrite(regwrite), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             imem_req, ir_write, pc_write, pcsrc, alusrc;
    logic [3:0]       aluctl;
    logic             regwrite, busy, halted, err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;   // expected retired-instruction count

  function automatic exp_t mk(bit req, bit irw, bit pcw, bit pcs, bit asrc,
                              logic [3:0] actl, bit rw, bit bsy, bit hlt, bit er);
    exp_t e;
    e.imem_req = req; e.ir_write = irw; e.pc_write = pcw; e.pcsrc = pcs;
    e.alusrc = asrc; e.aluctl = actl; e.regwrite = rw; e.busy = bsy;
    e.halted = hlt; e.err = er; e.cnt = CNT_W'(cnt);
    return e;
  endfunction

  function automatic exp_t x_idle();           return mk(0,0,0,0,0,4'b0010,0,0,0,0); endfunction
  function automatic exp_t x_fetch(bit r);     return mk(1,r,0,0,0,4'b0010,0,1,0,0); endfunction
  function automatic exp_t x_dec();            return mk(0,0,0,0,0,4'b0010,0,1,0,0); endfunction
  function automatic exp_t x_exec(bit a);      return mk(0,0,0,0,a,4'b0010,0,1,0,0); endfunction
  function automatic exp_t x_wb(bit a);        return mk(0,0,1,0,a,4'b0010,1,1,0,0); endfunction
  function automatic exp_t x_br(bit z);        return mk(0,0,1,z,0,4'b0110,0,1,0,0); endfunction
  function automatic exp_t x_halt();           return mk(0,0,0,0,0,4'b0010,0,0,1,1); endfunction

  task automatic step(input string tag, input bit s, input bit sp, input bit rdy,
                      input bit z, input bit r, input exp_t e);
    exp_t obs, ex;
    @(negedge clk);
    start = s; stop = sp; imem_ready = rdy; zero = z; rst = r;
    sb.push_back(e);
    #1;
    obs = {imem_req, ir_write, pc_write, pcsrc, alusrc, aluctl,
           regwrite, busy, halted, err, instr_count};
    ex = sb.pop_front();
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; zero = 0; imem_ready = 0;
    set_instr(7'b0, 3'b0, 7'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // reset state
    step("reset_idle", 0,0,0,0,0, x_idle());

    // 1: ADDI, no wait
    set_instr(7'b0010011, 3'b000, 7'b0);
    step("addi_idle_start", 1,0,1,0,0, x_idle());
    step("addi_fetch",      0,0,1,0,0, x_fetch(1));
    step("addi_decode",     0,0,0,0,0, x_dec());
    step("addi_exec",       0,0,0,0,0, x_exec(1));
    step("addi_wb",         0,1,0,0,0, x_wb(1));
    cnt++;
    step("addi_back_idle",  0,0,0,0,0, x_idle());

    // 2: BEQ taken, then not taken
    set_instr(7'b1100011, 3'b000, 7'b0);
    step("beq_idle_start",  1,0,1,0,0, x_idle());
    step("beq1_fetch",      0,0,1,0,0, x_fetch(1));
    step("beq1_decode",     0,0,0,0,0, x_dec());
    step("beq1_br_taken",   0,0,0,1,0, x_br(1));
    cnt++;
    step("beq2_fetch",      0,0,1,0,0, x_fetch(1));
    step("beq2_decode",     0,0,0,0,0, x_dec());
    step("beq2_br_nottkn",  0,1,0,0,0, x_br(0));
    cnt++;
    step("beq_back_idle",   0,0,0,0,0, x_idle());

    // 3: ADD with 3 stall cycles
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    step("add_idle_start",  1,0,0,0,0, x_idle());
    for (int i = 0; i < 3; i++) step("add_fetch_stall", 0,0,0,0,0, x_fetch(0));
    step("add_fetch_ready", 0,0,1,0,0, x_fetch(1));
    step("add_decode",      0,0,0,0,0, x_dec());
    step("add_exec",        0,0,0,0,0, x_exec(0));
    step("add_wb",          0,1,0,0,0, x_wb(0));
    cnt++;
    step("add_back_idle",   0,0,0,0,0, x_idle());

    // 6a: stop during EXEC is ignored; WB completes then IDLE
    set_instr(7'b0010011, 3'b000, 7'b0);
    step("stop_idle_start", 1,0,1,0,0, x_idle());
    step("stop_fetch",      0,0,1,0,0, x_fetch(1));
    step("stop_decode",     0,0,0,0,0, x_dec());
    step("stop_exec",       0,1,0,0,0, x_exec(1));
    step("stop_wb",         0,1,0,0,0, x_wb(1));
    cnt++;
    step("stop_idle",       0,0,0,0,0, x_idle());

    // 4: fetch timeout -> HALT, start ignored, reset clears
    step("to_idle_start",   1,0,0,0,0, x_idle());
    for (int i = 0; i < 15; i++) step("to_fetch_stall", 0,0,0,0,0, x_fetch(0));
    step("to_halt",         1,1,0,0,0, x_halt());
    step("to_halt_hold",    1,0,1,0,1, x_halt());
    cnt = 0;
    step("to_reset_idle",   0,0,0,0,0, x_idle());

    // 5a: illegal opcode
    set_instr(7'b0000011, 3'b000, 7'b0);
    step("ill_idle_start",  1,0,1,0,0, x_idle());
    step("ill_fetch",       0,0,1,0,0, x_fetch(1));
    step("ill_decode",      0,0,0,0,0, x_dec());
    step("ill_halt",        0,0,0,0,1, x_halt());
    step("ill_reset_idle",  0,0,0,0,0, x_idle());

    // 5b: ADD with funct7=0100000 is illegal here
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    step("sub_idle_start",  1,0,1,0,0, x_idle());
    step("sub_fetch",       0,0,1,0,0, x_fetch(1));
    step("sub_decode",      0,0,0,0,0, x_dec());
    step("sub_halt",        0,0,0,0,0, x_halt());
    step("sub_halt_hold",   0,0,0,0,1, x_halt());
    step("sub_reset_idle",  0,0,0,0,0, x_idle());

    // 6b: reset mid-FETCH
    step("rstf_idle_start", 1,0,0,0,0, x_idle());
    step("rstf_fetch",      0,0,0,0,1, x_fetch(0));
    step("rstf_idle",       0,0,0,0,0, x_idle());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
